mac_kbd_link: RTL and testbench
===============================

Name: mac_kbd_link

Overview:
Keyboard-side responder for the Mac Plus keyboard protocol. It consumes the toggle-strobed key events produced by the HID block and expands each event into protocol bytes held in a byte FIFO. It answers host commands decoded from the VIA shift-register path: Inquiry, Instant, Model Number and Test. It sits between the HID block and the VIA keyboard shift logic, in the same clock domain as both.

Parameters:
FIFO_DEPTH, 8, byte FIFO entries; power of two, >= 4.
INQ_TIMEOUT, 24'd8_000_000, cycles an Inquiry waits for a key before replying null (about 0.25 s at 32 MHz).
REPLY_DELAY, 16'd2000, cycles from command acceptance to reply, modelling keyboard serial latency; minimum 1.
MODEL_ID, 8'h0B, byte returned for Model Number.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
kbd_strobe  in  1  key event toggle; every level change is one event
kbd_data  in  10  [9] shift-prefix, [8] keypad-prefix, [7] break(1)/make(0), [6:0] Mac key code
cmd_strobe  in  1  one-cycle pulse, host command valid
cmd_data  in  8  host command byte
reply_strobe  out  1  one-cycle pulse, reply_data valid
reply_data  out  8  reply byte, held until the next reply
busy  out  1  high while a command is in progress (WAIT_INQ or DELAY)
overflow  out  1  sticky, set when an event is dropped; cleared only by reset or Model Number

Behaviour:
- Reset (async assert, sync release): reply_strobe=0, reply_data=8'h00, busy=0, overflow=0, FIFO empty, state IDLE, strobe history register=0. The HID block also resets kbd_strobe to 0, so no spurious event occurs.
- Event capture: on the cycle kbd_strobe differs from its registered copy, push the sequence, then update the copy. Key byte K = kbd_data[7:0].
  - [9]=1 pushes 71, 79, K, F1.
  - [9]=0 and [8]=1 pushes 79, K.
  - Otherwise pushes K.
  - The push is atomic, written 1 byte per cycle from a small expansion register. A new event arriving during expansion is captured after expansion completes. Only one event is pending; a further event is dropped and sets overflow.
  - If free entries are fewer than the sequence length, the whole event is dropped and overflow is set. No partial sequences are pushed.
- Command decode (IDLE only; cmd_strobe in any other state is ignored):
  - 10 Inquiry: if the FIFO is non-empty, go to DELAY with source=FIFO; otherwise go to WAIT_INQ and load the timeout counter.
  - 14 Instant: go to DELAY; source=FIFO if non-empty, else null (7B).
  - 16 Model Number: flush the FIFO, clear overflow, go to DELAY with source=MODEL_ID.
  - 36 Test: go to DELAY with source=7D (ACK).
  - Any other byte: no reply, stay in IDLE.
- WAIT_INQ: counter decrements each cycle.
  - When the FIFO becomes non-empty, go to DELAY with source=FIFO.
  - When the counter reaches 0, go to DELAY with source=7B.
  - A push and a timeout in the same cycle resolve in favour of the FIFO.
- DELAY: counts REPLY_DELAY cycles, then goes to REPLY.
  - The source is re-evaluated at REPLY only if it is FIFO, which is guaranteed non-empty because only REPLY pops.
- REPLY (1 cycle): reply_data is set to the byte and reply_strobe=1. If source=FIFO, pop the head in this same cycle. Return to IDLE.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- Latency: a command accepted at cycle N with reply available produces reply_strobe at N+1+REPLY_DELAY.
- busy=1 in WAIT_INQ and DELAY, 0 in IDLE and REPLY.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH+1 states wide; full and empty are derived from the count.
- Async reset mid-command aborts it with no reply and empties the FIFO.

Test Plan:
- Toggle kbd_strobe with kbd_data=10'h01B, then cmd 14 -> after REPLY_DELAY+1 cycles, one reply_strobe with reply_data=1B; a second 14 -> 7B.
- cmd 10 on an empty FIFO, then an event 10'h033 after 100 cycles -> reply 33 exactly REPLY_DELAY+1 cycles after the push becomes visible; no 7B is sent.
- cmd 10 with no events (INQ_TIMEOUT=1000 in the bench) -> reply 7B at cycle 1000+REPLY_DELAY+~2; busy is high throughout.
- Event 10'h30D (shift+keypad, make) followed by four cmd 14 -> replies 71, 79, 0D, F1; a fifth cmd 14 -> 7B.
- With FIFO_DEPTH=8, send 7 single-byte events, then one 10'h20D event -> the 4-byte event is dropped and overflow=1. cmd 16 -> reply 0B, FIFO empty, overflow=0. cmd 36 -> reply 7D.
- Assert reset_n low during DELAY of cmd 14 with a byte queued -> reply_strobe is never pulsed; after release, cmd 14 -> 7B.

Source files
------------

// File: rtl/mac_kbd_link_if.sv
// Signal bundle between the HID / VIA shift side and the Mac Plus keyboard responder.
// The master drives key events and host commands; the slave returns replies and status.
interface mac_kbd_link_if;
    logic       kbd_strobe;
    logic [9:0] kbd_data;
    logic       cmd_strobe;
    logic [7:0] cmd_data;
    logic       reply_strobe;
    logic [7:0] reply_data;
    logic       busy;
    logic       overflow;

    modport master (
        output kbd_strobe, kbd_data, cmd_strobe, cmd_data,
        input  reply_strobe, reply_data, busy, overflow
    );

    modport slave (
        input  kbd_strobe, kbd_data, cmd_strobe, cmd_data,
        output reply_strobe, reply_data, busy, overflow
    );
endinterface

// File: rtl/mac_kbd_link.sv
// Mac Plus keyboard responder: expands toggle-strobed key events into protocol bytes
// in a byte FIFO and answers Inquiry / Instant / Model Number / Test host commands.
module mac_kbd_link #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [23:0] INQ_TIMEOUT = 24'd8_000_000,
    parameter logic [15:0] REPLY_DELAY = 16'd2000,
    parameter logic [7:0]  MODEL_ID    = 8'h0B
) (
    input  logic          clk,
    input  logic          reset_n,
    mac_kbd_link_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;
    localparam logic [7:0] BYTE_NULL   = 8'h7B;
    localparam logic [7:0] BYTE_ACK    = 8'h7D;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_INQ, S_DELAY, S_REPLY} state_t;

    state_t state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic        src_fifo_q, src_fifo_d;
    logic [7:0]  src_byte_q, src_byte_d;
    logic [7:0]  reply_data_q, reply_data_d;
    logic        overflow_q, overflow_d;
    logic        strobe_q, strobe_d;
    logic        pend_valid_q, pend_valid_d;
    logic [9:0]  pend_data_q, pend_data_d;
    logic [31:0] exp_q, exp_d;
    logic [2:0]  exp_left_q, exp_left_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]  fifo_mem_q [FIFO_DEPTH];

    logic        event_in;
    logic        push;
    logic        pop;
    logic        flush;
    logic        ovf_clear;
    logic        drop;
    logic        start;
    logic [9:0]  cand;
    logic [2:0]  cand_len;
    logic [31:0] cand_bytes;
    logic        fifo_nonempty;
    logic        reply_strobe;
    logic        busy;
    logic [7:0]  reply_byte;

    assign fifo_nonempty = (count_q != '0);

    // ------------------------------------------------------------------
    // Event capture and expansion
    // ------------------------------------------------------------------
    always_comb begin
        event_in     = (bus.kbd_strobe != strobe_q);
        strobe_d     = bus.kbd_strobe;
        push         = (exp_left_q != 3'd0);
        exp_d        = push ? {exp_q[23:0], 8'h00} : exp_q;
        exp_left_d   = push ? exp_left_q - 3'd1 : exp_left_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        start        = 1'b0;
        drop         = 1'b0;
        cand         = pend_data_q;

        // Only one event may wait behind an expansion in progress.
        if (push) begin
            if (event_in) begin
                if (pend_valid_q) begin
                    drop = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_data_d  = bus.kbd_data;
                end
            end
        end else if (pend_valid_q) begin
            start        = 1'b1;
            cand         = pend_data_q;
            pend_valid_d = event_in;
            if (event_in) begin
                pend_data_d = bus.kbd_data;
            end
        end else if (event_in) begin
            start = 1'b1;
            cand  = bus.kbd_data;
        end

        if (cand[9]) begin
            cand_len   = 3'd4;
            cand_bytes = {8'h71, 8'h79, cand[7:0], 8'hF1};
        end else if (cand[8]) begin
            cand_len   = 3'd2;
            cand_bytes = {8'h79, cand[7:0], 16'h0000};
        end else begin
            cand_len   = 3'd1;
            cand_bytes = {cand[7:0], 24'h000000};
        end

        // Space is reserved for the whole sequence up front so it is never split.
        if (start) begin
            if (32'(count_q) + 32'(cand_len) > FIFO_DEPTH) begin
                drop = 1'b1;
            end else begin
                exp_d      = cand_bytes;
                exp_left_d = cand_len;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        src_fifo_d = src_fifo_q;
        src_byte_d = src_byte_q;
        flush      = 1'b0;
        ovf_clear  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_strobe) begin
                    case (bus.cmd_data)
                        CMD_INQUIRY: begin
                            if (fifo_nonempty) begin
                                state_d    = S_DELAY;
                                timer_d    = {8'h00, REPLY_DELAY};
                                src_fifo_d = 1'b1;
                            end else begin
                                state_d = S_WAIT_INQ;
                                timer_d = INQ_TIMEOUT;
                            end
                        end
                        CMD_INSTANT: begin
                            state_d    = S_DELAY;
                            timer_d    = {8'h00, REPLY_DELAY};
                            src_fifo_d = fifo_nonempty;
                            src_byte_d = BYTE_NULL;
                        end
                        CMD_MODEL: begin
                            flush      = 1'b1;
                            ovf_clear  = 1'b1;
                            state_d    = S_DELAY;
                            timer_d    = {8'h00, REPLY_DELAY};
                            src_fifo_d = 1'b0;
                            src_byte_d = MODEL_ID;
                        end
                        CMD_TEST: begin
                            state_d    = S_DELAY;
                            timer_d    = {8'h00, REPLY_DELAY};
                            src_fifo_d = 1'b0;
                            src_byte_d = BYTE_ACK;
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT_INQ: begin
                // A key arriving on the timeout cycle still wins.
                if (fifo_nonempty) begin
                    state_d    = S_DELAY;
                    timer_d    = {8'h00, REPLY_DELAY};
                    src_fifo_d = 1'b1;
                end else if (timer_q == 24'd0) begin
                    state_d    = S_DELAY;
                    timer_d    = {8'h00, REPLY_DELAY};
                    src_fifo_d = 1'b0;
                    src_byte_d = BYTE_NULL;
                end else begin
                    timer_d = timer_q - 24'd1;
                end
            end
            S_DELAY: begin
                if (timer_q <= 24'd1) begin
                    state_d = S_REPLY;
                end else begin
                    timer_d = timer_q - 24'd1;
                end
            end
            S_REPLY: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (state_q == S_WAIT_INQ) || (state_q == S_DELAY);
        reply_strobe = (state_q == S_REPLY);
        pop          = reply_strobe && src_fifo_q;
        reply_byte   = src_fifo_q ? fifo_mem_q[rd_ptr_q] : src_byte_q;
        reply_data_d = reply_strobe ? reply_byte : reply_data_q;
    end

    assign bus.reply_strobe = reply_strobe;
    assign bus.reply_data   = reply_data_d;
    assign bus.busy         = busy;
    assign bus.overflow     = overflow_q;

    // ------------------------------------------------------------------
    // FIFO bookkeeping and sticky overflow
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = CW'(push);
        end
        overflow_d = (overflow_q & ~ovf_clear) | drop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= exp_q[31:24];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= 24'd0;
            src_fifo_q   <= 1'b0;
            src_byte_q   <= 8'h00;
            reply_data_q <= 8'h00;
            overflow_q   <= 1'b0;
            strobe_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 10'h000;
            exp_q        <= 32'h0;
            exp_left_q   <= 3'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            src_fifo_q   <= src_fifo_d;
            src_byte_q   <= src_byte_d;
            reply_data_q <= reply_data_d;
            overflow_q   <= overflow_d;
            strobe_q     <= strobe_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            exp_q        <= exp_d;
            exp_left_q   <= exp_left_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_mac_kbd_link.sv
// Directed bench for mac_kbd_link: a table of key events and host commands with
// hand-computed replies, plus hand-written sequences for timing and reset corners.
module tb_mac_kbd_link;
    localparam int          RD    = 20;
    localparam logic [15:0] RD_P  = 16'd20;
    localparam logic [23:0] INQ_P = 24'd1000;
    localparam int          INQ   = 1000;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    mac_kbd_link_if bus();

    mac_kbd_link #(
        .FIFO_DEPTH  (8),
        .INQ_TIMEOUT (INQ_P),
        .REPLY_DELAY (RD_P),
        .MODEL_ID    (8'h0B)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_cmd;
        logic [9:0] data;
        bit         exp_rep;
        logic [7:0] exp_byte;
        bit         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_ev(logic [9:0] d, bit ovf);
        vec_t v;
        v.is_cmd = 1'b0; v.data = d; v.exp_rep = 1'b0; v.exp_byte = 8'h00; v.exp_ovf = ovf;
        vecs.push_back(v);
    endfunction

    function automatic void add_cmd(logic [7:0] c, bit rep, logic [7:0] b, bit ovf);
        vec_t v;
        v.is_cmd = 1'b1; v.data = {2'b00, c}; v.exp_rep = rep; v.exp_byte = b; v.exp_ovf = ovf;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send_event(input logic [9:0] d);
        bus.kbd_data   = d;
        bus.kbd_strobe = ~bus.kbd_strobe;
        repeat (8) @(negedge clk);
    endtask

    // Called at a negedge; counts strobes over max_cyc cycles and checks the first one.
    task automatic wait_reply(input string name, input int max_cyc, input bit exp_rep,
                              input int exp_idx, input logic [7:0] exp_byte);
        int         first   = 0;
        int         n       = 0;
        logic [7:0] got     = 8'h00;
        bit         busy_ok = 1'b1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (i == 1) bus.cmd_strobe = 1'b0;
            if (bus.reply_strobe) begin
                n++;
                if (first == 0) begin
                    first = i;
                    got   = bus.reply_data;
                end
            end else if (first == 0 && exp_rep && !bus.busy) begin
                busy_ok = 1'b0;
            end
        end
        if (exp_rep) begin
            check({name, " strobes"}, n, 1);
            check({name, " latency"}, first, exp_idx);
            check({name, " data"}, int'(got), int'(exp_byte));
            check({name, " busy"}, int'(busy_ok), 1);
            check({name, " hold"}, int'(bus.reply_data), int'(exp_byte));
        end else begin
            check({name, " no_reply"}, n, 0);
        end
        $display("TXN %s reply_count=%0d first=%0d data=%02h", name, n, first, got);
    endtask

    task automatic run_cmd(input string name, input logic [7:0] c, input bit rep,
                           input logic [7:0] b);
        bus.cmd_data   = c;
        bus.cmd_strobe = 1'b1;
        wait_reply(name, RD + 6, rep, RD + 1, b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n        = 1'b0;
        bus.kbd_strobe = 1'b0;
        bus.kbd_data   = 10'h000;
        bus.cmd_strobe = 1'b0;
        bus.cmd_data   = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst reply_strobe", int'(bus.reply_strobe), 0);
        check("rst reply_data", int'(bus.reply_data), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst overflow", int'(bus.overflow), 0);
        run_cmd("rst instant", 8'h14, 1'b1, 8'h7B);

        add_ev(10'h01B, 0);
        add_cmd(8'h14, 1, 8'h1B, 0);
        add_cmd(8'h14, 1, 8'h7B, 0);
        add_ev(10'h30D, 0);
        add_cmd(8'h14, 1, 8'h71, 0);
        add_cmd(8'h14, 1, 8'h79, 0);
        add_cmd(8'h14, 1, 8'h0D, 0);
        add_cmd(8'h14, 1, 8'hF1, 0);
        add_cmd(8'h14, 1, 8'h7B, 0);
        add_ev(10'h11E, 0);
        add_cmd(8'h10, 1, 8'h79, 0);
        add_cmd(8'h14, 1, 8'h1E, 0);
        add_ev(10'h09B, 0);
        add_cmd(8'h14, 1, 8'h9B, 0);
        add_cmd(8'h36, 1, 8'h7D, 0);
        add_cmd(8'h55, 0, 8'h00, 0);
        add_cmd(8'h00, 0, 8'h00, 0);
        for (int k = 1; k <= 7; k++) add_ev(10'(k), 0);
        add_ev(10'h20D, 1);
        add_cmd(8'h10, 1, 8'h01, 1);
        add_cmd(8'h16, 1, 8'h0B, 0);
        add_cmd(8'h14, 1, 8'h7B, 0);
        add_cmd(8'h36, 1, 8'h7D, 0);

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (vecs[i].is_cmd) begin
                run_cmd(nm, vecs[i].data[7:0], vecs[i].exp_rep, vecs[i].exp_byte);
            end else begin
                send_event(vecs[i].data);
                $display("TXN %s event data=%03h overflow=%0d", nm, vecs[i].data, bus.overflow);
            end
            check({nm, " overflow"}, int'(bus.overflow), int'(vecs[i].exp_ovf));
        end

        // Back-to-back events: one expands, one waits, the third is dropped.
        bus.kbd_data = 10'h30D; bus.kbd_strobe = ~bus.kbd_strobe;
        @(negedge clk);
        bus.kbd_data = 10'h01B; bus.kbd_strobe = ~bus.kbd_strobe;
        @(negedge clk);
        bus.kbd_data = 10'h01C; bus.kbd_strobe = ~bus.kbd_strobe;
        repeat (8) @(negedge clk);
        check("pend overflow", int'(bus.overflow), 1);
        $display("TXN pend burst overflow=%0d", bus.overflow);
        run_cmd("pend r0", 8'h14, 1'b1, 8'h71);
        run_cmd("pend r1", 8'h14, 1'b1, 8'h79);
        run_cmd("pend r2", 8'h14, 1'b1, 8'h0D);
        run_cmd("pend r3", 8'h14, 1'b1, 8'hF1);
        run_cmd("pend r4", 8'h14, 1'b1, 8'h1B);
        run_cmd("pend r5", 8'h14, 1'b1, 8'h7B);
        run_cmd("pend model", 8'h16, 1'b1, 8'h0B);
        check("pend ovf cleared", int'(bus.overflow), 0);

        // Inquiry on empty FIFO, key arrives 100 cycles later.
        bus.cmd_data = 8'h10; bus.cmd_strobe = 1'b1;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) bus.cmd_strobe = 1'b0;
            if (bus.reply_strobe || !bus.busy) n++;
        end
        check("inq wait idle_or_reply", n, 0);
        bus.kbd_data = 10'h033; bus.kbd_strobe = ~bus.kbd_strobe;
        wait_reply("inq event", RD + 8, 1'b1, RD + 3, 8'h33);
        run_cmd("inq after", 8'h14, 1'b1, 8'h7B);

        // Inquiry timeout with no key.
        bus.cmd_data = 8'h10; bus.cmd_strobe = 1'b1;
        wait_reply("inq timeout", INQ + RD + 8, 1'b1, INQ + RD + 2, 8'h7B);

        // Reset during DELAY aborts the reply and empties the FIFO.
        send_event(10'h01B);
        bus.cmd_data = 8'h14; bus.cmd_strobe = 1'b1;
        repeat (5) begin
            @(negedge clk);
            bus.cmd_strobe = 1'b0;
        end
        check("abort busy before", int'(bus.busy), 1);
        reset_n        = 1'b0;
        bus.kbd_strobe = 1'b0;
        #1;
        check("abort rst strobe", int'(bus.reply_strobe), 0);
        check("abort rst busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < RD + 10; i++) begin
            @(negedge clk);
            if (bus.reply_strobe) n++;
        end
        check("abort no_reply", n, 0);
        $display("TXN abort strobes_after_reset=%0d", n);
        run_cmd("abort instant", 8'h14, 1'b1, 8'h7B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
